// File: rtl/pwm_capture.sv
// Measures period, high time and 8-bit duty of an asynchronous PWM input.
// Duty/valid land 9 cycles after a capture; no backpressure, captures during a division raise overrun.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [7:0]       duty,
    output logic             valid,
    output logic             stuck_hi,
    output logic             stuck_lo,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic             sync1_q, sync2_q, sync_dly_q;
    logic             rise, fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [7:0]       duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             stuck_hi_q, stuck_hi_d;
    logic             stuck_lo_q, stuck_lo_d;
    logic             overrun_q, overrun_d;

    logic             busy_q, busy_d;
    logic [2:0]       it_q, it_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic [CNT_W-1:0] den_q, den_d;
    logic [7:0]       quo_q, quo_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   rem_sh, rem_nx, den_ext;
    logic             ge;
    logic [7:0]       quo_nx;
    logic             capture;

    assign rise = sync2_q & ~sync_dly_q;
    assign fall = ~sync2_q & sync_dly_q;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Restoring step: remainder stays below the divisor, so doubling fits in CNT_W+1 bits.
    assign den_ext = {1'b0, den_q};
    assign rem_sh  = rem_q << 1;
    assign ge      = (rem_sh >= den_ext);
    assign rem_nx  = ge ? (rem_sh - den_ext) : rem_sh;
    assign quo_nx  = (quo_q << 1) | {7'd0, ge};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        period_d   = period_q;
        high_d     = high_q;
        duty_d     = duty_q;
        stuck_hi_d = stuck_hi_q;
        stuck_lo_d = stuck_lo_q;
        valid_d    = 1'b0;
        overrun_d  = 1'b0;
        busy_d     = busy_q;
        it_d       = it_q;
        rem_d      = rem_q;
        den_d      = den_q;
        quo_d      = quo_q;
        capture    = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            snap_d  = '0;
            busy_d  = 1'b0;
            it_d    = '0;
            rem_d   = '0;
            den_d   = '0;
            quo_d   = '0;
        end else begin
            if (busy_q) begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                it_d  = it_q + 3'd1;
                if (it_q == 3'd7) begin
                    busy_d  = 1'b0;
                    duty_d  = quo_nx;
                    valid_d = 1'b1;
                end
            end

            if (rise) begin
                stuck_hi_d = 1'b0;
                stuck_lo_d = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        snap_d  = cnt_q;
                        cnt_d   = cnt_inc;
                    end else if (cnt_q == CNT_MAX) begin
                        // A stuck report replaces any in-flight division result.
                        state_d    = IDLE;
                        cnt_d      = '0;
                        stuck_hi_d = 1'b1;
                        stuck_lo_d = 1'b0;
                        duty_d     = 8'hFF;
                        valid_d    = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                        capture = 1'b1;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        stuck_lo_d = 1'b1;
                        stuck_hi_d = 1'b0;
                        duty_d     = 8'h00;
                        valid_d    = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (capture) begin
                period_d = cnt_q;
                high_d   = snap_q;
                if (busy_q) begin
                    overrun_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    it_d   = '0;
                    rem_d  = {1'b0, snap_q};
                    den_d  = cnt_q;
                    quo_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync_dly_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            snap_q     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            duty_q     <= '0;
            valid_q    <= 1'b0;
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            it_q       <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            quo_q      <= '0;
        end else begin
            sync1_q    <= pwm_in;
            sync2_q    <= sync1_q;
            sync_dly_q <= sync2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            period_q   <= period_d;
            high_q     <= high_d;
            duty_q     <= duty_d;
            valid_q    <= valid_d;
            stuck_hi_q <= stuck_hi_d;
            stuck_lo_q <= stuck_lo_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            it_q       <= it_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            quo_q      <= quo_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign duty      = duty_q;
    assign valid     = valid_q;
    assign stuck_hi  = stuck_hi_q;
    assign stuck_lo  = stuck_lo_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of steady PWM patterns plus hand-written corner sequences.
// Instances: a = 16-bit counters, b = 8-bit (stuck-high), c = 9-bit (stuck-low).
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic pwm_in = 1'b0;

    logic [15:0] per_a, hi_a;
    logic [7:0]  per_b, hi_b;
    logic [8:0]  per_c, hi_c;
    logic [7:0]  duty_a, duty_b, duty_c;
    logic        valid_a, valid_b, valid_c;
    logic        sthi_a, sthi_b, sthi_c;
    logic        stlo_a, stlo_b, stlo_c;
    logic        ovr_a, ovr_b, ovr_c;

    pwm_capture #(.CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
        .period(per_a), .high_time(hi_a), .duty(duty_a), .valid(valid_a),
        .stuck_hi(sthi_a), .stuck_lo(stlo_a), .overrun(ovr_a)
    );
    pwm_capture #(.CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
        .period(per_b), .high_time(hi_b), .duty(duty_b), .valid(valid_b),
        .stuck_hi(sthi_b), .stuck_lo(stlo_b), .overrun(ovr_b)
    );
    pwm_capture #(.CNT_W(9)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
        .period(per_c), .high_time(hi_c), .duty(duty_c), .valid(valid_c),
        .stuck_hi(sthi_c), .stuck_lo(stlo_c), .overrun(ovr_c)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Event log for instance a (cycle stamps), valid counts for b and c.
    int cyc = 0;
    int vq[$];
    int oq[$];
    int pq[$];
    logic [15:0] prev_per = '0;
    int v_b = 0;
    int v_c = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a) vq.push_back(cyc);
        if (ovr_a) oq.push_back(cyc);
        if (per_a != prev_per) pq.push_back(cyc);
        prev_per = per_a;
        if (valid_b) v_b++;
        if (valid_c) v_c++;
    end

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_per;
        int exp_high;
        int exp_duty;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic pwm_seq(input int hi, input int lo, input int reps);
        repeat (reps) begin
            pwm_in = 1'b1;
            cycles(hi);
            pwm_in = 1'b0;
            cycles(lo);
        end
    endtask

    int vs, os, ps, sb, sc, k;

    initial begin
        tbl[0] = '{64, 192, 3, 256, 64, 64};
        tbl[1] = '{3, 1, 3, 4, 3, 192};
        tbl[2] = '{128, 128, 3, 256, 128, 128};
        tbl[3] = '{1, 1, 3, 2, 1, 128};
        tbl[4] = '{10, 30, 3, 40, 10, 64};
        tbl[5] = '{1, 254, 3, 255, 1, 1};
        tbl[6] = '{254, 1, 3, 255, 254, 254};
        tbl[7] = '{5, 3, 3, 8, 5, 160};
        tbl[8] = '{7, 13, 3, 20, 7, 89};

        // Reset state
        cycles(3);
        chk("rst_period", per_a, 0);
        chk("rst_high", hi_a, 0);
        chk("rst_duty", duty_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_stuck_hi", sthi_a, 0);
        chk("rst_stuck_lo", stlo_a, 0);
        chk("rst_overrun", ovr_a, 0);
        rst = 1'b0;
        cycles(1);

        // Steady patterns
        for (int i = 0; i < 9; i++) begin
            do_reset();
            vs = vq.size();
            pwm_seq(tbl[i].hi, tbl[i].lo, tbl[i].reps);
            pwm_in = 1'b1;
            cycles(15);
            chk($sformatf("tbl%0d_period", i), per_a, tbl[i].exp_per);
            chk($sformatf("tbl%0d_high", i), hi_a, tbl[i].exp_high);
            chk($sformatf("tbl%0d_duty", i), duty_a, tbl[i].exp_duty);
            chk($sformatf("tbl%0d_valid_seen", i), vq.size() > vs, 1);
        end

        // 64/192: period visible in C+1, valid in C+9, so valid trails the period update by 8
        do_reset();
        vs = vq.size(); os = oq.size(); ps = pq.size();
        pwm_seq(64, 192, 4);
        pwm_in = 1'b1;
        cycles(14);
        chk("p64_valid_count", vq.size() - vs, 4);
        chk("p64_overrun_count", oq.size() - os, 0);
        chk("p64_period_updates", pq.size() - ps, 1);
        if (vq.size() - vs >= 2 && pq.size() > ps) begin
            chk("p64_valid_latency", vq[vs] - pq[ps], 8);
            chk("p64_valid_spacing", vq[vs+1] - vq[vs], 256);
        end else begin
            chk("p64_events_present", 0, 1);
        end
        chk("p64_duty", duty_a, 64);

        // 3/1: captures every 4 cycles, two dropped per division
        do_reset();
        vs = vq.size(); os = oq.size(); ps = pq.size();
        pwm_seq(3, 1, 10);
        pwm_in = 1'b1;
        cycles(20);
        chk("p31_valid_count", vq.size() - vs, 4);
        chk("p31_overrun_count", oq.size() - os, 6);
        if (vq.size() - vs >= 2 && oq.size() - os >= 2 && pq.size() > ps) begin
            chk("p31_valid_latency", vq[vs] - pq[ps], 8);
            chk("p31_valid_spacing", vq[vs+1] - vq[vs], 12);
            chk("p31_overrun_first", oq[os] - pq[ps], 4);
            chk("p31_overrun_second", oq[os+1] - pq[ps], 8);
        end else begin
            chk("p31_events_present", 0, 1);
        end
        chk("p31_period", per_a, 4);
        chk("p31_high", hi_a, 3);
        chk("p31_duty", duty_a, 192);

        // Stuck high on the 8-bit instance, then clear on the next rise
        do_reset();
        sb = v_b;
        pwm_in = 1'b1;
        cycles(300);
        chk("sthi_flag", sthi_b, 1);
        chk("sthi_duty", duty_b, 255);
        chk("sthi_valid_count", v_b - sb, 1);
        chk("sthi_period_untouched", per_b, 0);
        pwm_in = 1'b0;
        cycles(5);
        pwm_in = 1'b1;
        cycles(5);
        chk("sthi_cleared", sthi_b, 0);
        chk("sthi_no_new_valid", v_b - sb, 1);

        // 128/128 then constant low on the 9-bit instance
        do_reset();
        pwm_seq(128, 128, 3);
        pwm_in = 1'b1;
        cycles(20);
        chk("stlo_pre_duty", duty_c, 128);
        sc = v_c;
        pwm_in = 1'b0;
        k = 0;
        while (!stlo_c && k < 1000) begin
            cycles(1);
            k++;
        end
        chk("stlo_flag", stlo_c, 1);
        cycles(3);
        chk("stlo_duty", duty_c, 0);
        chk("stlo_valid_count", v_c - sc, 1);
        chk("stlo_period_held", per_c, 256);
        chk("stlo_stuck_hi", sthi_c, 0);

        // Reset four cycles after a capture, mid-division
        do_reset();
        pwm_in = 1'b1;
        cycles(20);
        pwm_in = 1'b0;
        cycles(20);
        pwm_in = 1'b1;
        k = 0;
        while (per_a == 0 && k < 20) begin
            cycles(1);
            k++;
        end
        chk("mrst_capture_seen", per_a, 40);
        cycles(3);
        vs = vq.size();
        pwm_in = 1'b0;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        chk("mrst_period", per_a, 0);
        chk("mrst_high", hi_a, 0);
        chk("mrst_duty", duty_a, 0);
        chk("mrst_valid", valid_a, 0);
        cycles(30);
        chk("mrst_no_valid", vq.size() - vs, 0);
        pwm_in = 1'b1;
        cycles(20);
        pwm_in = 1'b0;
        cycles(20);
        chk("mrst_one_rise_no_valid", vq.size() - vs, 0);
        pwm_in = 1'b1;
        cycles(15);
        chk("mrst_second_rise_valid", vq.size() - vs, 1);
        chk("mrst_period_new", per_a, 40);
        chk("mrst_duty_new", duty_a, 128);

        // Enable dropped in HIGH, restored, first rise after must not capture
        do_reset();
        pwm_seq(30, 10, 2);
        pwm_in = 1'b1;
        cycles(15);
        chk("en_pre_duty", duty_a, 192);
        enable = 1'b0;
        vs = vq.size(); os = oq.size();
        cycles(5);
        pwm_in = 1'b0;
        cycles(10);
        pwm_in = 1'b1;
        cycles(10);
        chk("en_off_period", per_a, 40);
        chk("en_off_high", hi_a, 30);
        chk("en_off_duty", duty_a, 192);
        chk("en_off_no_valid", vq.size() - vs, 0);
        chk("en_off_no_overrun", oq.size() - os, 0);
        enable = 1'b1;
        cycles(5);
        pwm_in = 1'b0;
        cycles(10);
        pwm_in = 1'b1;
        cycles(20);
        chk("en_first_rise_period", per_a, 40);
        chk("en_first_rise_no_valid", vq.size() - vs, 0);
        pwm_in = 1'b0;
        cycles(5);
        pwm_in = 1'b1;
        cycles(15);
        chk("en_capture_period", per_a, 25);
        chk("en_capture_high", hi_a, 20);
        chk("en_capture_duty", duty_a, 204);
        chk("en_capture_valid", vq.size() - vs, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, legal 8..24: width of the period/high-time counters.
REQ-002 The block SHALL have port clk  input  1  clock, all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port enable  input  1  measurement enable; 0 idles the block.
REQ-005 The block SHALL have port pwm_in  input  1  PWM signal to measure, asynchronous to clk.
REQ-006 The block SHALL have port period  output  CNT_W  last captured period, in clk cycles.
REQ-007 The block SHALL have port high_time  output  CNT_W  last captured high time, in clk cycles.
REQ-008 The block SHALL have port duty  output  8  duty estimate, 0..255.
REQ-009 The block SHALL have port valid  output  1  one-cycle pulse when duty updates.
REQ-010 The block SHALL have port stuck_hi  output  1  pwm_in high for the saturation time.
REQ-011 The block SHALL have port stuck_lo  output  1  pwm_in low for the saturation time.
REQ-012 The block SHALL have port overrun  output  1  one-cycle pulse when a capture is dropped.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer (s); edges are taken from s versus its 1-cycle delay; rise/fall detection lags pwm_in by 3 cycles.
REQ-014 The FSM SHALL have states IDLE, HIGH and LOW; IDLE->HIGH on rise; HIGH->LOW on fall; LOW->HIGH on rise (capture).
REQ-015 In the rise-detect cycle the counter cnt SHALL load 1; in every other cycle in HIGH or LOW it SHALL increment, saturating at 2^CNT_W-1.
REQ-016 In the fall-detect cycle the block SHALL latch high_snap <= cnt, so for H cycles high high_snap = H.
REQ-017 In a rise-detect cycle in LOW (capture) the block SHALL register period <= cnt (H+L) and high_time <= high_snap, and reload cnt to 1.
REQ-018 On capture with the divider idle, a restoring divider SHALL compute duty = floor(high_time*256/period) over 8 iterations in the 8 cycles after capture.
REQ-019 duty SHALL update and valid SHALL pulse in the 9th cycle after the capture cycle.
REQ-020 Because high_time < period, duty SHALL never exceed 255 and SHALL need no clamp.
REQ-021 The divider SHALL be idle again in the valid cycle.
REQ-022 A capture in any of cycles C+1..C+8 of an active division SHALL still update period and high_time, SHALL be discarded by the divider, and SHALL pulse overrun for 1 cycle.
REQ-023 cnt reaching 2^CNT_W-1 in HIGH with no edge SHALL set stuck_hi, set duty=255, pulse valid once and enter IDLE.
REQ-024 cnt reaching 2^CNT_W-1 in LOW with no edge SHALL set stuck_lo, set duty=0, pulse valid once and enter IDLE.
REQ-025 A stuck event SHALL abort any active division without a valid or overrun for it.
REQ-026 stuck_hi and stuck_lo SHALL clear in the next rise-detect cycle.
REQ-027 IDLE SHALL ignore falls, and the first rise SHALL NOT capture.
REQ-028 enable=0 SHALL force IDLE, clear cnt and high_snap, abort the divider, and suppress valid and overrun.
REQ-029 While enable=0, period, high_time, duty and the stuck flags SHALL hold.
REQ-030 Measurement SHALL restart at the first rise after enable returns to 1.

Reset
REQ-031 rst SHALL take priority over enable and all events.
REQ-032 rst SHALL clear the synchronizer to 0, FSM to IDLE, cnt, high_snap and divider to 0, and period, high_time, duty, valid, stuck_hi, stuck_lo and overrun to 0.
REQ-033 rst mid-measurement or mid-division SHALL discard the partial result with no valid in the cycle after release.

Verification
REQ-034 Repeating 64 high / 192 low SHALL give, from the second rise, period=256, high_time=64, duty=64 and valid 9 cycles after each capture.
REQ-035 Repeating 3 high / 1 low SHALL give period=4, high_time=3 and duty=192; overrun SHALL pulse at C+4 and C+8 and valid SHALL occur every 12 cycles.
REQ-036 With CNT_W=8, a rise then constant high SHALL set stuck_hi with duty=255 and one valid, then a fall and rise SHALL clear stuck_hi without a new valid.
REQ-037 A 128/128 stream then constant low SHALL give duty=128, then stuck_lo with duty=0 and one valid once cnt saturates in LOW.
REQ-038 rst asserted 4 cycles after a capture SHALL give all outputs 0, no valid, and the next valid only after two further rises.
REQ-039 enable dropped in HIGH then restored SHALL keep the outputs held, and the first post-enable rise SHALL NOT capture.
